// File: rtl/ccff_chain_loader_if.sv
// Host-side bundle for ccff_chain_loader: load control, word handshake,
// serial chain connection, status and readback.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              prog_clk_en;
    logic              busy;
    logic              done;
    logic              err;
    logic [WORD_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output start, abort, cfg_data, cfg_valid, ccff_tail,
        input  cfg_ready, ccff_head, prog_clk_en, busy, done, err, rdata, rvalid
    );

    modport slave (
        input  start, abort, cfg_data, cfg_valid, ccff_tail,
        output cfg_ready, ccff_head, prog_clk_en, busy, done, err, rdata, rvalid
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises host bitstream words into a ccff configuration chain, LSB first.
// Optional chain readback capture is enabled by defining CCFF_READBACK_EN.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 48,
    parameter int WORD_W    = 8
) (
    input logic                prog_clk,
    input logic                pReset_n,
    ccff_chain_loader_if.slave bus
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  word_idx;
    logic [WORD_W-1:0] shift_reg;
    logic              last_bit;
    logic              shifting;

    // bit_cnt counts bits already presented, including the one on ccff_head now.
    assign last_bit = (word_idx == IDX_LAST) || (bit_cnt == CNT_MAX);
    assign shifting = (state == SHIFT) && !bus.abort;

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch sees the pre-edge values regardless of statement order.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            word_idx        <= '0;
            shift_reg       <= '0;
            bus.cfg_ready   <= 1'b0;
            bus.ccff_head   <= 1'b0;
            bus.prog_clk_en <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if ((state == LOAD || state == SHIFT) && bus.abort) begin
                state           <= IDLE;
                bus.cfg_ready   <= 1'b0;
                bus.ccff_head   <= 1'b0;
                bus.prog_clk_en <= 1'b0;
                bus.busy        <= 1'b0;
                bus.err         <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state         <= LOAD;
                            bit_cnt       <= '0;
                            bus.err       <= 1'b0;
                            bus.busy      <= 1'b1;
                            bus.cfg_ready <= 1'b1;
                        end
                    end
                    LOAD: begin
                        // Bit 0 goes straight to the head; the rest wait in shift_reg.
                        if (bus.cfg_valid) begin
                            state           <= SHIFT;
                            bus.cfg_ready   <= 1'b0;
                            bus.ccff_head   <= bus.cfg_data[0];
                            bus.prog_clk_en <= 1'b1;
                            shift_reg       <= bus.cfg_data >> 1;
                            word_idx        <= '0;
                            bit_cnt         <= bit_cnt + 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (last_bit) begin
                            bus.ccff_head   <= 1'b0;
                            bus.prog_clk_en <= 1'b0;
                            if (bit_cnt == CNT_MAX) begin
                                state    <= DONE;
                                bus.done <= 1'b1;
                            end else begin
                                state         <= LOAD;
                                bus.cfg_ready <= 1'b1;
                            end
                        end else begin
                            bus.ccff_head <= shift_reg[0];
                            shift_reg     <= shift_reg >> 1;
                            word_idx      <= word_idx + 1'b1;
                            bit_cnt       <= bit_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] capture;

    // The tail bit sampled on a shift edge is the bit leaving the chain.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            capture    <= '0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rvalid <= 1'b0;
            if (shifting) begin
                if (last_bit) begin
                    bus.rdata  <= capture | (WORD_W'(bus.ccff_tail) << word_idx);
                    bus.rvalid <= 1'b1;
                end else begin
                    capture[word_idx] <= bus.ccff_tail;
                end
            end else if (state != SHIFT) begin
                capture <= '0;
            end
        end
    end
`else
    logic unused_readback;
    assign unused_readback = bus.ccff_tail ^ shifting;
    assign bus.rdata  = '0;
    assign bus.rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: a 48-bit loader (with a behavioural chain for readback)
// and a 10-bit loader for the partial final word.
module tb_ccff_chain_loader;
    localparam int W     = 8;
    localparam int LEN_A = 48;
    localparam int LEN_B = 10;
    localparam int LAT_A = LEN_A + (LEN_A + W - 1) / W + 2;
    localparam int LAT_B = LEN_B + (LEN_B + W - 1) / W + 2;

    logic prog_clk = 1'b0;
    logic pReset_n = 1'b1;
    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader_if #(.WORD_W(W)) a_if ();
    ccff_chain_loader_if #(.WORD_W(W)) b_if ();

    ccff_chain_loader #(.CHAIN_LEN(LEN_A), .WORD_W(W)) dut_a (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .bus      (a_if)
    );

    ccff_chain_loader #(.CHAIN_LEN(LEN_B), .WORD_W(W)) dut_b (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .bus      (b_if)
    );

    // Behavioural target chain: head enters bit 0, tail is the far end.
    logic [LEN_A-1:0] chain_a = '0;
    always @(posedge prog_clk) begin
        if (a_if.prog_clk_en) chain_a <= {chain_a[LEN_A-2:0], a_if.ccff_head};
    end
    assign a_if.ccff_tail = chain_a[LEN_A-1];
    assign b_if.ccff_tail = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int shifts_a = 0, shifts_b = 0, done_a = 0, done_b = 0, rv_cnt = 0;
    int done_cyc_a = 0, done_cyc_b = 0, start_cyc_a = 0, start_cyc_b = 0;
    int left_a = 0, left_b = 0;
    bit rb_track = 1'b0;
    logic       qa[$];
    logic       qb[$];
    logic [7:0] rq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    initial forever begin
        @(posedge prog_clk);
        cyc++;
    end

    // Output monitors: sample mid-cycle, pop the scoreboard on every chain shift.
    initial forever begin
        @(negedge prog_clk);
        if (a_if.prog_clk_en) begin
            shifts_a++;
            if (qa.size() == 0) check("a_extra_shift", 1, 0);
            else check("a_head", 32'(a_if.ccff_head), 32'(qa.pop_front()));
        end else begin
            check("a_head_idle", 32'(a_if.ccff_head), 0);
        end
        if (a_if.done) begin
            done_a++;
            done_cyc_a = cyc;
        end
`ifdef CCFF_READBACK_EN
        if (a_if.rvalid) begin
            rv_cnt++;
            if (rb_track) begin
                if (rq.size() == 0) check("a_extra_rvalid", 1, 0);
                else check("a_rdata", 32'(a_if.rdata), 32'(rq.pop_front()));
            end
        end
`else
        check("a_readback_tied", 32'({a_if.rvalid, a_if.rdata}), 0);
`endif
    end

    initial forever begin
        @(negedge prog_clk);
        if (b_if.prog_clk_en) begin
            shifts_b++;
            if (qb.size() == 0) check("b_extra_shift", 1, 0);
            else check("b_head", 32'(b_if.ccff_head), 32'(qb.pop_front()));
        end else begin
            check("b_head_idle", 32'(b_if.ccff_head), 0);
        end
        if (b_if.done) begin
            done_b++;
            done_cyc_b = cyc;
        end
    end

    task automatic start_a(input logic with_abort);
        a_if.start  = 1'b1;
        a_if.abort  = with_abort;
        start_cyc_a = cyc;
        left_a      = LEN_A;
        tick();
        a_if.start = 1'b0;
        a_if.abort = 1'b0;
    endtask

    task automatic feed_a(input logic [7:0] w, input logic [7:0] rb_exp);
        int   n;
        bit   ok;
        logic rdy;
        n = (left_a < W) ? left_a : W;
        for (int i = 0; i < n; i++) qa.push_back(w[i]);
        left_a -= n;
        if (rb_track) rq.push_back(rb_exp);
        a_if.cfg_data  = w;
        a_if.cfg_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge prog_clk);
            rdy = a_if.cfg_ready;
            tick();
            ok = rdy;
        end
        check("a_accept", 32'(ok), 1);
    endtask

    task automatic feed_b(input logic [7:0] w);
        int   n;
        bit   ok;
        logic rdy;
        n = (left_b < W) ? left_b : W;
        for (int i = 0; i < n; i++) qb.push_back(w[i]);
        left_b -= n;
        b_if.cfg_data  = w;
        b_if.cfg_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge prog_clk);
            rdy = b_if.cfg_ready;
            tick();
            ok = rdy;
        end
        check("b_accept", 32'(ok), 1);
    endtask

    task automatic wait_done_a(input int target);
        for (int t = 0; t < 200 && done_a < target; t++) tick();
        check("a_done_seen", done_a, target);
    endtask

    // Full 48-bit load of one repeated word; start may be paired with abort.
    task automatic full_load_a(input logic [7:0] w, input logic [7:0] rb_exp, input logic with_abort);
        int d0, s0;
        d0 = done_a;
        s0 = shifts_a;
        start_a(with_abort);
        check("load_busy", 32'(a_if.busy), 1);
        check("load_err_clear", 32'(a_if.err), 0);
        check("load_ready", 32'(a_if.cfg_ready), 1);
        for (int k = 0; k < LEN_A / W; k++) feed_a(w, rb_exp);
        a_if.cfg_valid = 1'b0;
        wait_done_a(d0 + 1);
        check("load_shifts", shifts_a - s0, LEN_A);
        check("load_latency", done_cyc_a - start_cyc_a + 1, LAT_A);
        check("load_queue_empty", qa.size(), 0);
        tick();
        tick();
        check("load_single_done", done_a, d0 + 1);
        check("load_idle_busy", 32'(a_if.busy), 0);
    endtask

    task automatic check_zero_a();
        check("rst_cfg_ready", 32'(a_if.cfg_ready), 0);
        check("rst_ccff_head", 32'(a_if.ccff_head), 0);
        check("rst_prog_clk_en", 32'(a_if.prog_clk_en), 0);
        check("rst_busy", 32'(a_if.busy), 0);
        check("rst_done", 32'(a_if.done), 0);
        check("rst_err", 32'(a_if.err), 0);
        check("rst_rdata", 32'(a_if.rdata), 0);
        check("rst_rvalid", 32'(a_if.rvalid), 0);
    endtask

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int d0, s0;
        bit ok;
        a_if.start = 1'b0; a_if.abort = 1'b0; a_if.cfg_data = '0; a_if.cfg_valid = 1'b0;
        b_if.start = 1'b0; b_if.abort = 1'b0; b_if.cfg_data = '0; b_if.cfg_valid = 1'b0;

        #2 pReset_n = 1'b0;
        #1 check_zero_a();
        repeat (3) tick();
        pReset_n = 1'b1;
        tick();

        // Partial final word on the 10-bit chain.
        b_if.start  = 1'b1;
        start_cyc_b = cyc;
        left_b      = LEN_B;
        tick();
        b_if.start = 1'b0;
        feed_b(8'hFF);
        feed_b(8'h03);
        b_if.cfg_valid = 1'b0;
        for (int t = 0; t < 100 && done_b < 1; t++) tick();
        check("b_done_seen", done_b, 1);
        check("b_shifts", shifts_b, LEN_B);
        check("b_latency", done_cyc_b - start_cyc_b + 1, LAT_B);
        check("b_queue_empty", qb.size(), 0);

        // Full load with cfg_valid held.
        full_load_a(8'hA5, 8'h00, 1'b0);

        // Back-pressure: 5-cycle valid gap between words 2 and 3.
        d0 = done_a;
        s0 = shifts_a;
        start_a(1'b0);
        feed_a(8'h3C, 8'h00);
        feed_a(8'hC3, 8'h00);
        a_if.cfg_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            tick();
            ok = a_if.cfg_ready;
        end
        check("bp_ready_wait", 32'(ok), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge prog_clk);
            check("bp_gap_ready", 32'(a_if.cfg_ready), 1);
            check("bp_gap_en", 32'(a_if.prog_clk_en), 0);
            tick();
        end
        for (int k = 0; k < 4; k++) feed_a(8'h69 + 8'(k), 8'h00);
        a_if.cfg_valid = 1'b0;
        wait_done_a(d0 + 1);
        check("bp_shifts", shifts_a - s0, LEN_A);

        // Abort after 20 bits.
        d0 = done_a;
        s0 = shifts_a;
        start_a(1'b0);
        for (int k = 0; k < 3; k++) feed_a(8'h96, 8'h00);
        a_if.cfg_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge prog_clk);
            #1;
            ok = (shifts_a - s0 >= 20);
        end
        check("abort_reach_bit20", 32'(ok), 1);
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        qa.delete();
        check("abort_busy", 32'(a_if.busy), 0);
        check("abort_err", 32'(a_if.err), 1);
        check("abort_en", 32'(a_if.prog_clk_en), 0);
        check("abort_ready", 32'(a_if.cfg_ready), 0);
        tick();
        check("abort_shifts", shifts_a - s0, 20);
        check("abort_no_done", done_a, d0);
        a_if.abort = 1'b1;
        tick();
        a_if.abort = 1'b0;
        check("idle_abort_err_sticky", 32'(a_if.err), 1);
        check("idle_abort_busy", 32'(a_if.busy), 0);
        full_load_a(8'h81, 8'h00, 1'b1);

        // Reset after 30 bits.
        d0 = done_a;
        s0 = shifts_a;
        start_a(1'b0);
        for (int k = 0; k < 4; k++) feed_a(8'h5A, 8'h00);
        a_if.cfg_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge prog_clk);
            #1;
            ok = (shifts_a - s0 >= 30);
        end
        check("reset_reach_bit30", 32'(ok), 1);
        pReset_n = 1'b0;
        #1 check_zero_a();
        a_if.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_start_ignored", 32'(a_if.busy), 0);
        end
        a_if.start = 1'b0;
        pReset_n = 1'b1;
        qa.delete();
        tick();
        tick();
        check("reset_no_done", done_a, d0);
        check("reset_shifts", shifts_a - s0, 30);

        // Preload zeros, then two loads whose readback is known.
        full_load_a(8'h00, 8'h00, 1'b0);
`ifdef CCFF_READBACK_EN
        rb_track = 1'b1;
        d0 = rv_cnt;
        full_load_a(8'hFF, 8'h00, 1'b0);
        check("rb_pulses_first", rv_cnt - d0, LEN_A / W);
        d0 = rv_cnt;
        full_load_a(8'h3C, 8'hFF, 1'b0);
        check("rb_pulses_second", rv_cnt - d0, LEN_A / W);
        check("rb_queue_empty", rq.size(), 0);
`else
        full_load_a(8'hFF, 8'h00, 1'b0);
        full_load_a(8'h3C, 8'h00, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
